// File: rtl/sweep_pkg.sv
// sweep_pkg: shared types and constants for the
// frequency-sweep sounding sequencer.
package sweep_pkg;

   localparam int FREQW_W = 32;
   localparam int STEP_W  = 16;
   localparam int REP_W   = 8;
   localparam int TO_W    = 16;

   localparam int DEF_SETTLE_CYCLES = 100;
   localparam int DEF_ACK_TIMEOUT   = 16;
   localparam int DEF_DONE_TIMEOUT  = 65535;

   typedef enum logic [3:0] {
      IDLE,
      WAIT_INIT,
      F_REQ,
      F_ACK,
      F_WAIT,
      SETTLE,
      G_REQ,
      G_ACK,
      G_WAIT,
      NEXT,
      FIN
   } state_t;

   typedef enum logic [1:0] {
      HS_IDLE,
      HS_ACK,
      HS_WAIT
   } hs_phase_t;

   typedef struct packed {
      logic [FREQW_W-1:0] step_freqw;
      logic [STEP_W-1:0]  step_num;
      logic [REP_W-1:0]   repeat_num;
   } sweep_cfg_t;

   // Counters start at 1 on entry (the entry cycle counts),
   // so the last count of an n-cycle window is n-1.
   function automatic logic [TO_W-1:0] last_count(input int n);
      return (n > 1) ? TO_W'(n - 1) : TO_W'(1);
   endfunction

endpackage

// File: rtl/ovr_handshake.sv
// ovr_handshake: tracks one request/OVER handshake and
// flags ack, completion or timeout of either phase.
module ovr_handshake
   import sweep_pkg::*;
#(
   parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT,
   parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT
) (
   input  logic CLOCK_10M,
   input  logic RESET_N,
   input  logic clear,
   input  logic req,
   input  logic over,
   output logic acked,
   output logic done,
   output logic timeout
);

   localparam logic [TO_W-1:0] ACK_LAST  = last_count(ACK_TIMEOUT);
   localparam logic [TO_W-1:0] DONE_LAST = last_count(DONE_TIMEOUT);

   hs_phase_t       phase;
   logic [TO_W-1:0] cnt;

   assign acked   = (phase == HS_ACK) && !over;
   assign done    = (phase == HS_WAIT) && over;
   assign timeout = ((phase == HS_ACK) && over && (cnt >= ACK_LAST))
                 || ((phase == HS_WAIT) && !over && (cnt >= DONE_LAST));

   // Phase tracking; the window counter restarts on each phase entry.
   always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
      if (!RESET_N) begin
         phase <= HS_IDLE;
         cnt   <= '0;
      end else if (clear) begin
         phase <= HS_IDLE;
         cnt   <= '0;
      end else begin
         unique case (phase)
            HS_IDLE: begin
               if (req) begin
                  phase <= HS_ACK;
                  cnt   <= TO_W'(1);
               end
            end
            HS_ACK: begin
               if (acked) begin
                  phase <= HS_WAIT;
                  cnt   <= TO_W'(1);
               end else if (timeout) begin
                  phase <= HS_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + TO_W'(1);
               end
            end
            HS_WAIT: begin
               if (done || timeout) begin
                  phase <= HS_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + TO_W'(1);
               end
            end
            default: begin
               phase <= HS_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/sweep_sequencer.sv
// sweep_sequencer: steps the DDS tuning word and fires a
// burst of coded pulses at each frequency of the sweep.
module sweep_sequencer
   import sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT,
   parameter int DONE_TIMEOUT  = DEF_DONE_TIMEOUT
) (
   input  logic               CLOCK_10M,
   input  logic               RESET_N,
   input  logic               START,
   input  logic               ABORT,
   input  logic [FREQW_W-1:0] START_FREQW,
   input  logic [FREQW_W-1:0] STEP_FREQW,
   input  logic [STEP_W-1:0]  STEP_NUM,
   input  logic [REP_W-1:0]   REPEAT_NUM,
   input  logic               INIT_OK,
   input  logic               FREQW_UPDATE_OVER,
   input  logic               GEN_OVER,
   output logic [FREQW_W-1:0] FREQW,
   output logic               FREQW_UPDATE,
   output logic               GEN,
   output logic               FRAME_SYNC,
   output logic [STEP_W-1:0]  FREQ_INDEX,
   output logic [REP_W-1:0]   PULSE_INDEX,
   output logic               BUSY,
   output logic               DONE,
   output logic               ERR
);

   localparam logic [TO_W-1:0] SETTLE_LAST = last_count(SETTLE_CYCLES);

   state_t          state;
   sweep_cfg_t      cfg;
   logic [TO_W-1:0] settle_cnt;
   logic [REP_W:0]  pulse_nx;
   logic [STEP_W:0] freq_nx;

   logic f_acked, f_done, f_to;
   logic g_acked, g_done, g_to;

   assign pulse_nx = {1'b0, PULSE_INDEX} + (REP_W+1)'(1);
   assign freq_nx  = {1'b0, FREQ_INDEX} + (STEP_W+1)'(1);

   ovr_handshake #(
      .ACK_TIMEOUT  (ACK_TIMEOUT),
      .DONE_TIMEOUT (DONE_TIMEOUT)
   ) u_retune_hs (
      .CLOCK_10M (CLOCK_10M),
      .RESET_N   (RESET_N),
      .clear     (ABORT),
      .req       (FREQW_UPDATE),
      .over      (FREQW_UPDATE_OVER),
      .acked     (f_acked),
      .done      (f_done),
      .timeout   (f_to)
   );

   ovr_handshake #(
      .ACK_TIMEOUT  (ACK_TIMEOUT),
      .DONE_TIMEOUT (DONE_TIMEOUT)
   ) u_gen_hs (
      .CLOCK_10M (CLOCK_10M),
      .RESET_N   (RESET_N),
      .clear     (ABORT),
      .req       (GEN),
      .over      (GEN_OVER),
      .acked     (g_acked),
      .done      (g_done),
      .timeout   (g_to)
   );

   // Sweep FSM with registered request, status and index outputs.
   always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
      if (!RESET_N) begin
         state        <= IDLE;
         cfg          <= '0;
         settle_cnt   <= '0;
         FREQW        <= '0;
         FREQW_UPDATE <= 1'b0;
         GEN          <= 1'b0;
         FRAME_SYNC   <= 1'b0;
         FREQ_INDEX   <= '0;
         PULSE_INDEX  <= '0;
         BUSY         <= 1'b0;
         DONE         <= 1'b0;
         ERR          <= 1'b0;
      end else begin
         FREQW_UPDATE <= 1'b0;
         GEN          <= 1'b0;
         FRAME_SYNC   <= 1'b0;
         DONE         <= 1'b0;
         if (ABORT) begin
            state <= IDLE;
            BUSY  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (START) begin
                     cfg.step_freqw <= STEP_FREQW;
                     cfg.step_num   <= STEP_NUM;
                     cfg.repeat_num <= (REPEAT_NUM == '0)
                                     ? REP_W'(1) : REPEAT_NUM;
                     FREQW       <= START_FREQW;
                     FREQ_INDEX  <= '0;
                     PULSE_INDEX <= '0;
                     ERR         <= 1'b0;
                     BUSY        <= 1'b1;
                     state <= (STEP_NUM == '0) ? FIN : WAIT_INIT;
                  end
               end
               WAIT_INIT: begin
                  if (INIT_OK) state <= F_REQ;
               end
               F_REQ: begin
                  FREQW_UPDATE <= 1'b1;
                  state        <= F_ACK;
               end
               F_ACK: begin
                  if (f_to) begin
                     ERR   <= 1'b1;
                     BUSY  <= 1'b0;
                     state <= IDLE;
                  end else if (f_acked) begin
                     state <= F_WAIT;
                  end
               end
               F_WAIT: begin
                  if (f_done) begin
                     settle_cnt <= TO_W'(1);
                     state      <= SETTLE;
                  end else if (f_to) begin
                     ERR   <= 1'b1;
                     BUSY  <= 1'b0;
                     state <= IDLE;
                  end
               end
               SETTLE: begin
                  if (settle_cnt >= SETTLE_LAST) state <= G_REQ;
                  else settle_cnt <= settle_cnt + TO_W'(1);
               end
               G_REQ: begin
                  if (GEN_OVER) begin
                     GEN        <= 1'b1;
                     FRAME_SYNC <= 1'b1;
                     state      <= G_ACK;
                  end
               end
               G_ACK: begin
                  if (g_to) begin
                     ERR   <= 1'b1;
                     BUSY  <= 1'b0;
                     state <= IDLE;
                  end else if (g_acked) begin
                     state <= G_WAIT;
                  end
               end
               G_WAIT: begin
                  if (g_done) begin
                     state <= NEXT;
                  end else if (g_to) begin
                     ERR   <= 1'b1;
                     BUSY  <= 1'b0;
                     state <= IDLE;
                  end
               end
               NEXT: begin
                  if (pulse_nx < {1'b0, cfg.repeat_num}) begin
                     PULSE_INDEX <= pulse_nx[REP_W-1:0];
                     state       <= G_REQ;
                  end else if (freq_nx < {1'b0, cfg.step_num}) begin
                     PULSE_INDEX <= '0;
                     FREQ_INDEX  <= freq_nx[STEP_W-1:0];
                     FREQW       <= FREQW + cfg.step_freqw;
                     state       <= F_REQ;
                  end else begin
                     state <= FIN;
                  end
               end
               FIN: begin
                  DONE  <= 1'b1;
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sweep_sequencer.sv
// tb_sweep_sequencer: directed scenarios against a simple
// DDS / pulse-generator model.
`timescale 1ns/1ps
module tb_sweep_sequencer;

   localparam int F_BUSY = 3;

   logic        CLOCK_10M = 1'b0;
   logic        RESET_N;
   logic        START, ABORT;
   logic [31:0] START_FREQW, STEP_FREQW;
   logic [15:0] STEP_NUM;
   logic [7:0]  REPEAT_NUM;
   logic        INIT_OK;
   logic        FREQW_UPDATE_OVER, GEN_OVER;
   logic [31:0] FREQW;
   logic        FREQW_UPDATE, GEN, FRAME_SYNC;
   logic [15:0] FREQ_INDEX;
   logic [7:0]  PULSE_INDEX;
   logic        BUSY, DONE, ERR;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic       dds_dead = 1'b0;
   int         g_busy   = 2;
   logic [7:0] fcnt     = 8'd0;
   logic [7:0] gcnt     = 8'd0;

   int          fu_n    = 0;
   int          done_n  = 0;
   int          done_c  = 0;
   int          fs_bad  = 0;
   int          gfall_n = 0;
   logic        f_prev  = 1'b1;
   logic        g_prev  = 1'b1;
   logic [31:0] gen_freqw[$];
   logic [15:0] gen_fidx[$];
   logic [7:0]  gen_pidx[$];
   int          gen_cyc[$];
   int          rise_cyc[$];

   sweep_sequencer dut (
      .CLOCK_10M         (CLOCK_10M),
      .RESET_N           (RESET_N),
      .START             (START),
      .ABORT             (ABORT),
      .START_FREQW       (START_FREQW),
      .STEP_FREQW        (STEP_FREQW),
      .STEP_NUM          (STEP_NUM),
      .REPEAT_NUM        (REPEAT_NUM),
      .INIT_OK           (INIT_OK),
      .FREQW_UPDATE_OVER (FREQW_UPDATE_OVER),
      .GEN_OVER          (GEN_OVER),
      .FREQW             (FREQW),
      .FREQW_UPDATE      (FREQW_UPDATE),
      .GEN               (GEN),
      .FRAME_SYNC        (FRAME_SYNC),
      .FREQ_INDEX        (FREQ_INDEX),
      .PULSE_INDEX       (PULSE_INDEX),
      .BUSY              (BUSY),
      .DONE              (DONE),
      .ERR               (ERR)
   );

   always #50 CLOCK_10M = ~CLOCK_10M;

   always @(posedge CLOCK_10M) cyc <= cyc + 1;

   // DDS model: OVER low for F_BUSY cycles after each retune request.
   always @(posedge CLOCK_10M) begin
      if (FREQW_UPDATE && !dds_dead) fcnt <= 8'(F_BUSY);
      else if (fcnt != 8'd0) fcnt <= fcnt - 8'd1;
   end
   assign FREQW_UPDATE_OVER = (fcnt == 8'd0);

   // Pulse generator model: OVER low for g_busy cycles per GEN.
   always @(posedge CLOCK_10M) begin
      if (GEN) gcnt <= 8'(g_busy);
      else if (gcnt != 8'd0) gcnt <= gcnt - 8'd1;
   end
   assign GEN_OVER = (gcnt == 8'd0);

   // Event log sampled mid-cycle.
   always @(negedge CLOCK_10M) begin
      if (FREQW_UPDATE) fu_n <= fu_n + 1;
      if (GEN) begin
         gen_freqw.push_back(FREQW);
         gen_fidx.push_back(FREQ_INDEX);
         gen_pidx.push_back(PULSE_INDEX);
         gen_cyc.push_back(cyc);
      end
      if (GEN !== FRAME_SYNC) fs_bad <= fs_bad + 1;
      if (DONE) begin
         done_n <= done_n + 1;
         done_c <= cyc;
      end
      if (FREQW_UPDATE_OVER && !f_prev) rise_cyc.push_back(cyc);
      if (!GEN_OVER && g_prev) gfall_n <= gfall_n + 1;
      f_prev <= FREQW_UPDATE_OVER;
      g_prev <= GEN_OVER;
   end

   task automatic do_start(input logic [31:0] f0, input logic [31:0] st,
                           input logic [15:0] n, input logic [7:0] r,
                           output int c);
      @(negedge CLOCK_10M);
      START_FREQW = f0;
      STEP_FREQW  = st;
      STEP_NUM    = n;
      REPEAT_NUM  = r;
      START       = 1'b1;
      c           = cyc;
      @(negedge CLOCK_10M);
      START = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLOCK_10M);
         if (!BUSY) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (2) @(negedge CLOCK_10M);
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_vec++;
      if (BUSY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0) begin
         n_err++;
         $display("FAIL reset_status: busy/done/err=%b%b%b want 000",
                  BUSY, DONE, ERR);
      end
      n_vec++;
      if (FREQW_UPDATE !== 1'b0 || GEN !== 1'b0 || FRAME_SYNC !== 1'b0) begin
         n_err++;
         $display("FAIL reset_req: fu/gen/fs=%b%b%b want 000",
                  FREQW_UPDATE, GEN, FRAME_SYNC);
      end
      n_vec++;
      if (FREQW !== 32'd0 || FREQ_INDEX !== 16'd0 || PULSE_INDEX !== 8'd0) begin
         n_err++;
         $display("FAIL reset_regs: freqw=%h fi=%0d pi=%0d want 0",
                  FREQW, FREQ_INDEX, PULSE_INDEX);
      end
   endtask

   task automatic test_single();
      int c, b, fu0, d0, fs0, gf0;
      bit ok;
      b = gen_cyc.size(); fu0 = fu_n; d0 = done_n; fs0 = fs_bad; gf0 = gfall_n;
      do_start(32'd370440929, 32'd5, 16'd1, 8'd3, c);
      wait_idle(3000, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL single_idle: busy stuck want 0"); end
      n_vec++;
      if (fu_n - fu0 !== 1) begin
         n_err++; $display("FAIL single_fu: got %0d want 1", fu_n - fu0);
      end
      n_vec++;
      if (gen_cyc.size() - b !== 3) begin
         n_err++; $display("FAIL single_gen: got %0d want 3", gen_cyc.size() - b);
      end
      n_vec++;
      if (fs_bad - fs0 !== 0) begin
         n_err++; $display("FAIL single_fsync: got %0d misaligned want 0", fs_bad - fs0);
      end
      n_vec++;
      if (gfall_n - gf0 !== 3) begin
         n_err++; $display("FAIL single_genover: got %0d falls want 3", gfall_n - gf0);
      end
      if (gen_cyc.size() >= b + 3) begin
         for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (gen_pidx[b+i] !== 8'(i) || gen_freqw[b+i] !== 32'd370440929) begin
               n_err++;
               $display("FAIL single_pulse%0d: pi=%0d fw=%0d want pi=%0d fw=370440929",
                        i, gen_pidx[b+i], gen_freqw[b+i], i);
            end
         end
      end
      n_vec++;
      if (done_n - d0 !== 1 || ERR !== 1'b0) begin
         n_err++;
         $display("FAIL single_done: done=%0d err=%b want 1 0", done_n - d0, ERR);
      end
      n_vec++;
      if (FREQW !== 32'd370440929 || PULSE_INDEX !== 8'd2) begin
         n_err++;
         $display("FAIL single_hold: fw=%0d pi=%0d want 370440929 2",
                  FREQW, PULSE_INDEX);
      end
   endtask

   task automatic test_sweep();
      int c, b, rb, d0;
      bit ok;
      logic [31:0] wf[3];
      wf[0] = 32'hFFFF_FFF0;
      wf[1] = 32'h0000_0000;
      wf[2] = 32'h0000_0010;
      b = gen_cyc.size(); rb = rise_cyc.size(); d0 = done_n;
      do_start(32'hFFFF_FFF0, 32'h10, 16'd3, 8'd1, c);
      wait_idle(3000, ok);
      n_vec++;
      if (!ok || gen_cyc.size() - b !== 3) begin
         n_err++;
         $display("FAIL sweep_gen: got %0d gens ok=%b want 3 1", gen_cyc.size() - b, ok);
      end
      if (gen_cyc.size() >= b + 3) begin
         for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (gen_freqw[b+i] !== wf[i] || gen_fidx[b+i] !== 16'(i)) begin
               n_err++;
               $display("FAIL sweep_step%0d: fw=%h fi=%0d want %h %0d",
                        i, gen_freqw[b+i], gen_fidx[b+i], wf[i], i);
            end
         end
      end
      if (gen_cyc.size() > b && rise_cyc.size() > rb) begin
         n_vec++;
         if (gen_cyc[b] - rise_cyc[rb] !== 101) begin
            n_err++;
            $display("FAIL sweep_settle: got %0d cycles want 101",
                     gen_cyc[b] - rise_cyc[rb]);
         end
      end
      n_vec++;
      if (done_n - d0 !== 1) begin
         n_err++; $display("FAIL sweep_done: got %0d want 1", done_n - d0);
      end
   endtask

   task automatic test_timeout();
      int c, k, e, b, d0;
      bit ok, seen;
      dds_dead = 1'b1;
      b = gen_cyc.size(); d0 = done_n;
      k = 0; e = 0; seen = 1'b0;
      do_start(32'h1234_0000, 32'h100, 16'd2, 8'd1, c);
      for (int i = 0; i < 100; i++) begin
         if (FREQW_UPDATE) begin k = cyc; seen = 1'b1; break; end
         @(negedge CLOCK_10M);
      end
      for (int i = 0; i < 100 && seen; i++) begin
         @(negedge CLOCK_10M);
         if (!BUSY) begin e = cyc; break; end
      end
      #1;
      n_vec++;
      if (!seen || e - k !== 16) begin
         n_err++;
         $display("FAIL timeout_lat: seen=%b got %0d cycles want 16", seen, e - k);
      end
      n_vec++;
      if (ERR !== 1'b1 || BUSY !== 1'b0) begin
         n_err++; $display("FAIL timeout_err: err=%b busy=%b want 1 0", ERR, BUSY);
      end
      repeat (3) @(negedge CLOCK_10M);
      #1;
      n_vec++;
      if (gen_cyc.size() - b !== 0 || done_n - d0 !== 0) begin
         n_err++;
         $display("FAIL timeout_quiet: gen=%0d done=%0d want 0 0",
                  gen_cyc.size() - b, done_n - d0);
      end
      dds_dead = 1'b0;
      d0 = done_n;
      do_start(32'h1234_0000, 32'h100, 16'd1, 8'd1, c);
      n_vec++;
      if (ERR !== 1'b0 || BUSY !== 1'b1) begin
         n_err++; $display("FAIL timeout_clear: err=%b busy=%b want 0 1", ERR, BUSY);
      end
      wait_idle(3000, ok);
      n_vec++;
      if (!ok || done_n - d0 !== 1 || ERR !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_rerun: ok=%b done=%0d err=%b want 1 1 0",
                  ok, done_n - d0, ERR);
      end
   endtask

   task automatic test_boundaries();
      int c, b, fu0, d0;
      bit ok;
      b = gen_cyc.size(); fu0 = fu_n; d0 = done_n;
      do_start(32'hAAAA_0000, 32'h1, 16'd0, 8'd4, c);
      wait_idle(20, ok);
      n_vec++;
      if (done_n - d0 !== 1 || done_c - c !== 2) begin
         n_err++;
         $display("FAIL step0_done: n=%0d lat=%0d want 1 2", done_n - d0, done_c - c);
      end
      n_vec++;
      if (fu_n - fu0 !== 0 || gen_cyc.size() - b !== 0) begin
         n_err++;
         $display("FAIL step0_quiet: fu=%0d gen=%0d want 0 0", fu_n - fu0,
                  gen_cyc.size() - b);
      end
      b = gen_cyc.size(); d0 = done_n;
      do_start(32'h0000_0100, 32'h1, 16'd1, 8'd0, c);
      wait_idle(3000, ok);
      n_vec++;
      if (gen_cyc.size() - b !== 1 || done_n - d0 !== 1) begin
         n_err++;
         $display("FAIL rep0: gen=%0d done=%0d want 1 1", gen_cyc.size() - b,
                  done_n - d0);
      end
      INIT_OK = 1'b0;
      b = gen_cyc.size(); fu0 = fu_n;
      do_start(32'h0000_0200, 32'h1, 16'd1, 8'd1, c);
      repeat (1000) @(negedge CLOCK_10M);
      #1;
      n_vec++;
      if (fu_n - fu0 !== 0 || BUSY !== 1'b1) begin
         n_err++;
         $display("FAIL init_hold: fu=%0d busy=%b want 0 1", fu_n - fu0, BUSY);
      end
      INIT_OK = 1'b1;
      wait_idle(3000, ok);
      n_vec++;
      if (fu_n - fu0 !== 1 || gen_cyc.size() - b !== 1) begin
         n_err++;
         $display("FAIL init_release: fu=%0d gen=%0d want 1 1", fu_n - fu0,
                  gen_cyc.size() - b);
      end
   endtask

   task automatic test_abort();
      int c, b, g_a, fu_a, d0;
      bit ok, seen;
      g_busy = 10;
      d0 = done_n;
      seen = 1'b0;
      do_start(32'h0000_1000, 32'h100, 16'd3, 8'd2, c);
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLOCK_10M);
         if (GEN && FREQ_INDEX == 16'd1) begin seen = 1'b1; break; end
      end
      repeat (3) @(negedge CLOCK_10M);
      ABORT = 1'b1;
      @(negedge CLOCK_10M);
      n_vec++;
      if (!seen || BUSY !== 1'b0) begin
         n_err++; $display("FAIL abort_busy: seen=%b busy=%b want 1 0", seen, BUSY);
      end
      ABORT = 1'b0;
      #1;
      g_a = gen_cyc.size(); fu_a = fu_n;
      repeat (300) @(negedge CLOCK_10M);
      #1;
      n_vec++;
      if (gen_cyc.size() !== g_a || fu_n !== fu_a || done_n !== d0) begin
         n_err++;
         $display("FAIL abort_quiet: gen+%0d fu+%0d done+%0d want 0 0 0",
                  gen_cyc.size() - g_a, fu_n - fu_a, done_n - d0);
      end
      g_busy = 2;
      b = gen_cyc.size();
      do_start(32'h0000_1000, 32'h100, 16'd1, 8'd1, c);
      wait_idle(3000, ok);
      n_vec++;
      if (gen_cyc.size() <= b) begin
         n_err++; $display("FAIL abort_restart: got 0 gens want 1");
      end else if (gen_freqw[b] !== 32'h1000 || gen_fidx[b] !== 16'd0) begin
         n_err++;
         $display("FAIL abort_restart: fw=%h fi=%0d want 00001000 0",
                  gen_freqw[b], gen_fidx[b]);
      end
   endtask

   task automatic test_reset_mid();
      int c, rb, b, d0;
      bit ok, seen;
      rb = rise_cyc.size();
      seen = 1'b0;
      do_start(32'h5555_5555, 32'h1, 16'd1, 8'd1, c);
      for (int i = 0; i < 200; i++) begin
         @(negedge CLOCK_10M);
         if (rise_cyc.size() > rb) begin seen = 1'b1; break; end
      end
      repeat (20) @(negedge CLOCK_10M);
      #13;
      RESET_N = 1'b0;
      #1;
      n_vec++;
      if (!seen || BUSY !== 1'b0 || FREQW !== 32'd0 || ERR !== 1'b0
          || DONE !== 1'b0 || GEN !== 1'b0 || FREQW_UPDATE !== 1'b0) begin
         n_err++;
         $display("FAIL rst_async: seen=%b busy=%b fw=%h want 1 0 00000000",
                  seen, BUSY, FREQW);
      end
      repeat (2) @(negedge CLOCK_10M);
      RESET_N = 1'b1;
      b = gen_cyc.size();
      repeat (200) @(negedge CLOCK_10M);
      #1;
      n_vec++;
      if (BUSY !== 1'b0 || gen_cyc.size() !== b) begin
         n_err++;
         $display("FAIL rst_idle: busy=%b gen=%0d want 0 0", BUSY, gen_cyc.size() - b);
      end
      d0 = done_n;
      do_start(32'h0, 32'h0, 16'd0, 8'd1, c);
      wait_idle(20, ok);
      n_vec++;
      if (done_n - d0 !== 1) begin
         n_err++; $display("FAIL rst_restart: done=%0d want 1", done_n - d0);
      end
   endtask

   initial begin
      RESET_N     = 1'b0;
      START       = 1'b0;
      ABORT       = 1'b0;
      START_FREQW = '0;
      STEP_FREQW  = '0;
      STEP_NUM    = '0;
      REPEAT_NUM  = '0;
      INIT_OK     = 1'b1;
      repeat (3) @(negedge CLOCK_10M);
      test_reset();
      @(negedge CLOCK_10M);
      RESET_N = 1'b1;
      test_single();
      test_sweep();
      test_timeout();
      test_boundaries();
      test_abort();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sweep_sequencer.md
Name: sweep_sequencer

Overview:
- Frequency-sweep sounding controller placed directly upstream of the AD9911 signal generator.
- Steps the carrier tuning word from a start value by a fixed increment.
- At each frequency, requests a DDS retune, waits for the retune to complete, lets the DDS settle, then fires a programmed number of coded pulses.
- Tracks frequency and pulse indices and emits a frame marker to the receiver/ADC path.

Parameters:
- SETTLE_CYCLES, 100, CLOCK_10M cycles between retune completion and the first GEN of a frequency (10 us).
- ACK_TIMEOUT, 16, max cycles for a handshake OVER signal to drop after its request pulse.
- DONE_TIMEOUT, 65535, max cycles for an OVER signal to return high after dropping.

Ports:
- CLOCK_10M  in  1  system clock, 10 MHz
- RESET_N  in  1  asynchronous active-low reset
- START  in  1  one-cycle pulse; latches the config and begins the sweep (ignored unless IDLE)
- ABORT  in  1  level; forces IDLE
- START_FREQW  in  32  first tuning word
- STEP_FREQW  in  32  tuning-word increment per step
- STEP_NUM  in  16  number of frequencies
- REPEAT_NUM  in  8  pulses per frequency
- INIT_OK  in  1  DDS init complete
- FREQW_UPDATE_OVER  in  1  retune complete (low while busy)
- GEN_OVER  in  1  pulse train complete (low while busy)
- FREQW  out  32  current tuning word, held
- FREQW_UPDATE  out  1  one-cycle retune request
- GEN  out  1  one-cycle pulse-generation request
- FRAME_SYNC  out  1  one-cycle marker coincident with each GEN
- FREQ_INDEX  out  16  current step index
- PULSE_INDEX  out  8  current repeat index
- BUSY  out  1  high outside IDLE
- DONE  out  1  one-cycle pulse at normal sweep completion
- ERR  out  1  sticky handshake-timeout flag, cleared by the next accepted START

Behaviour:
- Reset (asynchronous, RESET_N=0): every output is 0, state is IDLE, and the latched config is cleared.
- On START in IDLE:
  - Latch START_FREQW, STEP_FREQW and STEP_NUM.
  - Latch REPEAT_NUM; a value of 0 is latched as 1.
  - Set FREQW=START_FREQW, clear both indices, clear ERR, set BUSY=1, go to WAIT_INIT.
  - If STEP_NUM=0: go to FIN instead, with no requests issued.
- WAIT_INIT: stay until INIT_OK=1, then go to F_REQ. There is no timeout in this state.
- F_REQ: drive FREQW_UPDATE=1 for exactly one cycle, go to F_ACK.
- F_ACK: wait for FREQW_UPDATE_OVER=0.
  - If it is not seen within ACK_TIMEOUT cycles: set ERR and go to IDLE.
  - Otherwise go to F_WAIT.
- F_WAIT: wait for FREQW_UPDATE_OVER=1.
  - Timeout after DONE_TIMEOUT cycles: set ERR and go to IDLE.
  - Otherwise go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to G_REQ. SETTLE_CYCLES=0 passes through in one cycle.
- G_REQ: precondition is GEN_OVER=1; wait here while it is 0. Then assert GEN and FRAME_SYNC for one cycle and go to G_ACK.
- G_ACK and G_WAIT: same rules as F_ACK and F_WAIT, applied to GEN_OVER.
- NEXT:
  - If PULSE_INDEX+1 < latched REPEAT_NUM: increment PULSE_INDEX, go to G_REQ (no retune, no settle).
  - Otherwise, if FREQ_INDEX+1 < latched STEP_NUM: clear PULSE_INDEX, increment FREQ_INDEX, set FREQW <= FREQW + STEP_FREQW (32-bit, wraps modulo 2^32 with no flag), go to F_REQ.
  - Otherwise go to FIN.
- FIN: pulse DONE for one cycle, set BUSY=0, go to IDLE. FREQW and both indices hold their last values.
- ABORT=1 in any state: next cycle is IDLE with BUSY=0. No DONE pulse, ERR unchanged, no further requests. A request pulse being driven that cycle is suppressed.
- START while BUSY: ignored.
- START and ABORT in the same cycle: ABORT wins.
- Request pulses are registered outputs and are never back-to-back.
- Minimum gap between consecutive GENs at one frequency: ACK plus WAIT phases plus 2 cycles.
- Timeout counters are 16 bits and restart on every state entry.

Decomposition:
- Package sweep_pkg holds:
  - the state enum: IDLE, WAIT_INIT, F_REQ, F_ACK, F_WAIT, SETTLE, G_REQ, G_ACK, G_WAIT, NEXT, FIN;
  - the default timeout constants;
  - the counter width constants.
- One sub-module, ovr_handshake, instantiated twice (retune path and gen path). It takes a request strobe and an OVER input, runs the ACK and DONE timeouts, and reports done or timeout.

Test Plan:
- Single frequency, 3 pulses: START_FREQW=370440929, STEP_NUM=1, REPEAT_NUM=3, with a model DDS/generator attached.
  - Expect one FREQW_UPDATE, then 3 GEN pulses, each separated by a GEN_OVER low/high cycle.
  - Expect FRAME_SYNC coincident with each GEN, FREQW constant, DONE once, ERR=0.
- Sweep: START_FREQW=0xFFFFFFF0, STEP_FREQW=0x10, STEP_NUM=3, REPEAT_NUM=1.
  - Expect FREQW sequence 0xFFFFFFF0, 0x00000000, 0x00000010 (wrap) and FREQ_INDEX 0, 1, 2.
  - Expect the first GEN exactly SETTLE_CYCLES+1 cycles after FREQW_UPDATE_OVER rises.
- Timeout: the model never drops FREQW_UPDATE_OVER.
  - Expect ERR=1 and BUSY=0 ACK_TIMEOUT cycles after FREQW_UPDATE, with no GEN and no DONE.
  - Expect the next START to clear ERR.
- Boundaries:
  - STEP_NUM=0: DONE is seen 2 cycles after START, with no requests.
  - REPEAT_NUM=0: behaves as 1.
  - INIT_OK held low for 1000 cycles: no FREQW_UPDATE appears until it rises.
- Abort mid-sweep: ABORT during G_WAIT at FREQ_INDEX=1.
  - Expect BUSY=0 the next cycle, no further GEN/FREQW_UPDATE, no DONE.
  - A subsequent START restarts from START_FREQW.
- Reset mid-operation: RESET_N pulled low asynchronously (not on a clock edge) during SETTLE.
  - Expect all outputs 0 immediately, and IDLE after release.
